// File: rtl/mem_fold_sequencer.sv
// Job sequencer around one shared MW x BW memory: LOAD streams words in, PROC adds INC
// to every word with a one-access-per-cycle pipelined read-modify-write, DRAIN streams words out.
module mem_fold_sequencer #(
    parameter int BW  = 8,
    parameter int MW  = 16,
    parameter int AW  = 4,
    parameter int INC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_LOAD  = 2'd1;
    localparam logic [1:0]    S_PROC  = 2'd2;
    localparam logic [1:0]    S_DRAIN = 2'd3;
    localparam logic [AW-1:0] LAST    = AW'(MW - 1);
    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [BW-1:0] INC_W   = BW'(INC);

    logic [BW-1:0] mem [MW];
    logic [BW-1:0] rd_data_q;
    logic [BW-1:0] out_data_q;

    logic [1:0]    state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    // rd_pend: a PROC read is in flight; rd_done: all MW reads (PROC) or issues (DRAIN) are made
    logic          rd_pend_q, rd_pend_d;
    logic          rd_done_q, rd_done_d;

    logic          mem_we;
    logic          rd_en;
    logic          out_load;
    logic [BW-1:0] mem_wdata;

    assign mem_wdata = (state_q == S_PROC) ? rd_data_q + INC_W : in_data;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_pend_d   = rd_pend_q;
        rd_done_d   = rd_done_q;
        mem_we      = 1'b0;
        rd_en       = 1'b0;
        out_load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is not a new job.
                if (start && !done_q) begin
                    state_d  = S_LOAD;
                    busy_d   = 1'b1;
                    wr_ptr_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST) begin
                        wr_ptr_d  = '0;
                        rd_ptr_d  = '0;
                        rd_pend_d = 1'b0;
                        rd_done_d = 1'b0;
                        state_d   = S_PROC;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE;
                    end
                end
            end
            S_PROC: begin
                rd_pend_d = !rd_done_q;
                if (!rd_done_q) begin
                    rd_en = 1'b1;
                    if (rd_ptr_q == LAST) begin
                        rd_ptr_d  = '0;
                        rd_done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE;
                    end
                end
                if (rd_pend_q) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST) begin
                        wr_ptr_d  = '0;
                        rd_done_d = 1'b0;
                        state_d   = S_DRAIN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    if (!rd_done_q) begin
                        out_load    = 1'b1;
                        out_valid_d = 1'b1;
                        if (rd_ptr_q == LAST) begin
                            rd_ptr_d  = '0;
                            rd_done_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + ONE;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                        if (out_valid_q) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the storage array carries no reset so it maps onto a plain synchronous RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= mem_wdata;
        if (rd_en)  rd_data_q     <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_pend_q   <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_pend_q   <= rd_pend_d;
            rd_done_q   <= rd_done_d;
            if (out_load) out_data_q <= mem[rd_ptr_q];
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mem_fold_sequencer.sv
// Scoreboard bench for mem_fold_sequencer: loaded words push (word+INC) mod 2^BW, a negedge
// monitor pops on every output handshake; job timing, stalls, resets and stray starts are probed.
module tb_mem_fold_sequencer;

    localparam int BW  = 8;
    localparam int MW  = 16;
    localparam int AW  = 4;
    localparam int INC = 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    mem_fold_sequencer #(.BW(BW), .MW(MW), .AW(AW), .INC(INC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            vectors     = 0;
    int            miscompares = 0;
    int            done_cnt    = 0;
    bit            job_over    = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] job_data [MW];
    bit            hold_pend   = 0;
    logic [BW-1:0] hold_data   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each accepted word comes back once, in load order, as (word + INC) mod 2^BW.
    function automatic logic [BW-1:0] model(input logic [BW-1:0] w);
        int s;
        s = (int'(w) + INC) % (1 << BW);
        return BW'(s);
    endfunction

    always @(negedge clk) begin
        logic [BW-1:0] e;
        if (done) done_cnt++;
        if (hold_pend) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
        end
        hold_pend = !rst && out_valid && !out_ready;
        hold_data = out_data;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_nonempty", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("drain_word", out_data, e);
            end
        end
    end

    task automatic loader(input int vmode);
        int i = 0;
        int c = 0;
        while (i < MW && c < 1000) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (c % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = job_data[i];
            check("in_ready_load", in_ready, 1);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(job_data[i]));
                i++;
            end
            tick();
            c++;
        end
        in_valid = 1'b0;
        check("load_count", i, MW);
        check("in_ready_after_load", in_ready, 0);
    endtask

    task automatic ready_drv(input int rmode);
        int hs    = 0;
        int stall = 5;
        while (!job_over) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(hs == 3 && out_valid && stall > 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (rmode == 1 && hs == 3 && out_valid && stall > 0) stall--;
            if (out_valid && out_ready) hs++;
            tick();
        end
        if (rmode == 1) check("stall_applied", stall, 0);
        out_ready = 1'b1;
    endtask

    task automatic waiter(input bit timing);
        int n       = 0;
        int first_v = -1;
        int d0      = done_cnt;
        bit got     = 0;
        while (n < 3000 && !got) begin
            tick();
            n++;
            if (n == 1) check("busy_after_start", busy, 1);
            if (out_valid && first_v < 0) first_v = n;
            if (done) got = 1;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("busy_at_done", busy, 0);
            if (timing) begin
                check("done_edge", n, 3 * MW + 2);
                check("first_out_valid_edge", first_v, 2 * MW + 2);
            end
            start = 1'b1;
            tick();
            start = 1'b0;
            check("done_one_cycle", done, 0);
            check("start_at_done_ignored", in_ready, 0);
            check("idle_busy", busy, 0);
            check("done_pulses", done_cnt - d0, 1);
        end
        job_over = 1;
    endtask

    task automatic noise(input bit en);
        if (en) begin
            while (!done && !job_over) begin
                start = 1'($urandom_range(0, 1));
                tick();
            end
        end
    endtask

    task automatic run_job(input int vmode, input int rmode, input bit nz, input bit timing);
        job_over = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        fork
            loader(vmode);
            ready_drv(rmode);
            waiter(timing);
            noise(nz);
        join
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;

        // Load data offered while idle must not start anything
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b1;
        repeat (4) tick();
        check("idle_in_valid_ready", in_ready, 0);
        check("idle_in_valid_busy", busy, 0);
        in_valid = 1'b0;

        for (int i = 0; i < MW; i++) job_data[i] = BW'(8'h10 + i);
        run_job(0, 0, 0, 1);

        for (int i = 0; i < MW; i++) job_data[i] = BW'(i);
        run_job(1, 0, 0, 0);

        for (int i = 0; i < MW; i++) job_data[i] = BW'($urandom);
        run_job(0, 1, 0, 0);

        for (int i = 0; i < MW; i++) job_data[i] = 8'hFF;
        run_job(0, 0, 0, 0);
        for (int i = 0; i < MW; i++) job_data[i] = 8'hFE;
        run_job(1, 2, 0, 0);

        for (int i = 0; i < MW; i++) job_data[i] = BW'($urandom);
        run_job(2, 2, 1, 0);

        // Abort a job in PROC cycle 5, then run a clean one
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < MW; i++) begin
            in_valid = 1'b1;
            in_data  = BW'(8'h80 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_idle", in_ready, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < MW; i++) job_data[i] = BW'(8'h40 + i);
        run_job(0, 0, 0, 1);

        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < MW; i++) job_data[i] = BW'($urandom);
            run_job(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 0);
        end

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
